adder_tree_acc_ctrl: RTL and testbench

- Sequencer/accumulator wrapped around the combinational adder tree in the DSP path of LeNet5.
- After a start pulse it takes a programmed number of NUM-lane input beats over a valid/ready handshake and presents each beat to the tree through a register stage.
- It accumulates the tree sums into a wide accumulator and emits one result per job on a valid/ready output.
- Typical use: one neuron/channel dot-product reduction longer than NUM lanes.

---
 rtl/adder_tree_acc_ctrl_if.sv | 43 ++++
 rtl/adder_tree_acc_ctrl.sv | 113 +++++++++++
 tb/tb_adder_tree_acc_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_acc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_acc_ctrl_if
// Purpose  : Bundles the job control, input beat stream, tree operand/sum
//            path and result stream of adder_tree_acc_ctrl.
// Modports : master - job issuer / stream source / tree model / result sink
//            slave  - the sequencer (adder_tree_acc_ctrl)
// Signals  : start, len, busy         - job control
//            in_valid, in_ready, in_data - input beat handshake
//            tree_a, tree_sum         - operand vector to / sum from the tree
//            out_valid, out_ready, out_data - result handshake
// Revision : 1.0 - initial release
// ============================================================================
interface adder_tree_acc_ctrl_if #(
    parameter int IN_WIDTH  = 8,
    parameter int NUM       = 16,
    parameter int OUT_WIDTH = 32,
    parameter int ACC_WIDTH = 40,
    parameter int LEN_WIDTH = 8
) ();
    logic                          start;
    logic [LEN_WIDTH-1:0]          len;
    logic                          busy;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM*IN_WIDTH-1:0]       in_data;
    logic [NUM*IN_WIDTH-1:0]       tree_a;
    logic signed [OUT_WIDTH-1:0]   tree_sum;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACC_WIDTH-1:0]   out_data;

    modport master (
        output start, len, in_valid, in_data, tree_sum, out_ready,
        input  busy, in_ready, tree_a, out_valid, out_data
    );

    modport slave (
        input  start, len, in_valid, in_data, tree_sum, out_ready,
        output busy, in_ready, tree_a, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/adder_tree_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_acc_ctrl
// Purpose  : Sequencer/accumulator around an external combinational adder
//            tree. After a start pulse it accepts len NUM-lane beats, registers
//            each beat onto the tree input, sums the tree results into a wide
//            signed accumulator and emits one result per job.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - adder_tree_acc_ctrl_if.slave (job control, input beats,
//                    tree operand/sum, result handshake)
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_acc_ctrl #(
    parameter int IN_WIDTH  = 8,
    parameter int NUM       = 16,
    parameter int OUT_WIDTH = 32,
    parameter int ACC_WIDTH = 40,   // must be >= OUT_WIDTH
    parameter int LEN_WIDTH = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    adder_tree_acc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t                       r_state;
    logic [LEN_WIDTH-1:0]         r_rem;        // beats still to be accepted
    logic                         r_pipe_v;     // r_tree_a holds a fresh beat
    logic [NUM*IN_WIDTH-1:0]      r_tree_a;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  r_out_data;
    logic                         r_out_valid;

    logic                         w_in_ready;
    logic                         w_accept;
    logic signed [ACC_WIDTH-1:0]  w_acc_sum;

    // Outputs are pure functions of registers.
    assign w_in_ready = (r_state == S_ACCUM) && (r_rem != '0);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Sized cast of a signed operand sign-extends the tree sum; the add wraps.
    assign w_acc_sum  = r_acc + ACC_WIDTH'(bus.tree_sum);

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.in_ready  = w_in_ready;
    assign bus.tree_a    = r_tree_a;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_pipe_v    <= 1'b0;
            r_tree_a    <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pipe_v <= 1'b0;
                    // A zero-length job is dropped without leaving IDLE.
                    if (bus.start && (bus.len != '0)) begin
                        r_rem   <= bus.len;
                        r_acc   <= '0;
                        r_state <= S_ACCUM;
                    end
                end

                S_ACCUM: begin
                    if (w_accept) begin
                        r_tree_a <= bus.in_data;
                        r_pipe_v <= 1'b1;
                        r_rem    <= r_rem - LEN_WIDTH'(1);
                    end else begin
                        r_pipe_v <= 1'b0;
                    end

                    // tree_sum reflects the beat registered last cycle.
                    // rem==0 here means that beat was the job's last one,
                    // and no further accept can happen this cycle.
                    if (r_pipe_v) begin
                        r_acc <= w_acc_sum;
                        if (r_rem == '0) begin
                            r_out_data  <= w_acc_sum;
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUTPUT;
                        end
                    end
                end

                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_adder_tree_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_acc_ctrl
// Purpose  : Self-checking bench for adder_tree_acc_ctrl. Models the adder
//            tree as the signed sum of the 16 lanes of tree_a; expected job
//            results are queued at job start and checked by a monitor on
//            every result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_acc_ctrl;
    localparam int IN_WIDTH  = 8;
    localparam int NUM       = 16;
    localparam int OUT_WIDTH = 32;
    localparam int ACC_WIDTH = 40;
    localparam int LEN_WIDTH = 8;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   last_acc;

    logic signed [ACC_WIDTH-1:0] exp_q[$];
    logic signed [OUT_WIDTH-1:0] w_tree_sum;

    adder_tree_acc_ctrl_if #(
        .IN_WIDTH (IN_WIDTH),
        .NUM      (NUM),
        .OUT_WIDTH(OUT_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .LEN_WIDTH(LEN_WIDTH)
    ) bus ();

    adder_tree_acc_ctrl #(
        .IN_WIDTH (IN_WIDTH),
        .NUM      (NUM),
        .OUT_WIDTH(OUT_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference adder tree: signed sum of the lanes.
    always_comb begin
        w_tree_sum = '0;
        for (int i = 0; i < NUM; i++)
            w_tree_sum = w_tree_sum + OUT_WIDTH'($signed(bus.tree_a[i*IN_WIDTH +: IN_WIDTH]));
    end
    assign bus.tree_sum = w_tree_sum;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every result handshake pops one expected value.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got 0x%0h expected none", bus.out_data);
            end else begin
                check("result", 64'(bus.out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic start_job(input int l);
        bus.start = 1'b1;
        bus.len   = LEN_WIDTH'(l);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = 8'hAA;   // must not matter once latched
    endtask

    task automatic send_beat(input logic [7:0] lane);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = {NUM{lane}};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                last_acc = cyc;
                break;
            end
        end
        if (!ok) check("beat_accept_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {NUM{8'hEE}};
    endtask

    // Waits for the result (out_ready already high), checks latency and
    // that busy drops the cycle after the handshake.
    task automatic wait_result(input string tag, input bit chk_lat);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check({tag, "_out_valid_timeout"}, 64'(ok), 64'd1);
        end else begin
            if (chk_lat) check({tag, "_latency"}, 64'(cyc - last_acc), 64'd2);
            check({tag, "_busy_in_handshake"}, 64'(bus.busy), 64'd1);
            @(negedge clk);
            check({tag, "_busy_after"}, 64'({bus.busy, bus.out_valid}), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] vpat;
        bit ok;
        int acc_cnt;
        logic signed [ACC_WIDTH-1:0] held;

        n_checks = 0; n_pass = 0; last_acc = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
        bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_tree_a",    64'(bus.tree_a == '0), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Scenario 1: all ones, len 4 -> 64
        exp_q.push_back(40'sd64);
        start_job(4);
        repeat (4) send_beat(8'h01);
        wait_result("s1", 1'b1);

        // Scenario 2: all -1, len 3 -> -48; then 0x7F / 0x80 -> -16
        exp_q.push_back(-40'sd48);
        start_job(3);
        repeat (3) send_beat(8'hFF);
        wait_result("s2a", 1'b1);
        exp_q.push_back(-40'sd16);
        start_job(2);
        send_beat(8'h7F);
        send_beat(8'h80);
        wait_result("s2b", 1'b1);

        // Scenario 3: stalls and backpressure, len 5, lanes 2 -> 160
        bus.out_ready = 1'b0;
        exp_q.push_back(40'sd160);
        start_job(5);
        vpat = 8'b1101_1001;   // applied LSB first: 1,0,0,1,1,0,1,1
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = vpat[i];
            bus.in_data  = vpat[i] ? {NUM{8'h02}} : {NUM{8'h33}};
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1'b1; break; end
        end
        check("s3_out_valid_seen", 64'(ok), 64'd1);
        held = 40'sd160;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.start = (i == 2);
            bus.len   = 8'd3;
            bus.in_valid = 1'b1;           // ignored: in_ready is low
            bus.in_data  = {NUM{8'h55}};
            @(negedge clk);
            check("s3_hold_valid",    64'(bus.out_valid), 64'd1);
            check("s3_hold_data",     64'(bus.out_data),  64'(held));
            check("s3_hold_in_ready", 64'(bus.in_ready),  64'd0);
            check("s3_hold_busy",     64'(bus.busy),      64'd1);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_result("s3", 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("s3_no_second_job", 64'({bus.busy, bus.out_valid}), 64'd0);

        // Scenario 4: len edge cases
        start_job(0);
        repeat (3) @(negedge clk);
        check("s4_len0_idle", 64'({bus.busy, bus.out_valid}), 64'd0);
        @(posedge clk); #1;
        exp_q.push_back(40'sd80);
        start_job(1);
        send_beat(8'h05);
        wait_result("s4_len1", 1'b1);

        exp_q.push_back(40'sd4080);
        start_job(255);
        bus.in_valid = 1'b1;
        bus.in_data  = {NUM{8'h01}};
        acc_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (bus.out_valid) begin ok = 1'b1; break; end
        end
        check("s4_len255_done", 64'(ok), 64'd1);
        check("s4_len255_accepts", 64'(acc_cnt), 64'd255);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Scenario 5: asynchronous reset mid-job
        start_job(4);
        send_beat(8'h07);
        send_beat(8'h07);
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_rst_busy",      64'(bus.busy),      64'd0);
        check("s5_rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("s5_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("s5_rst_out_data",  64'(bus.out_data),  64'd0);
        check("s5_rst_tree_a",    64'(bus.tree_a == '0), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(40'sd96);
        start_job(2);
        repeat (2) send_beat(8'h03);
        wait_result("s5", 1'b1);

        // Scenario 6: start in the handshake cycle is ignored, next accepted
        exp_q.push_back(40'sd64);
        start_job(2);
        repeat (2) send_beat(8'h02);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1'b1; break; end
        end
        check("s6_out_valid_seen", 64'(ok), 64'd1);
        bus.start = 1'b1;
        bus.len   = 8'd5;
        @(posedge clk); #1;
        check("s6_start_in_handshake_ignored", 64'(bus.busy), 64'd0);
        bus.len = 8'd1;
        exp_q.push_back(40'sd160);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("s6_next_start_accepted", 64'({bus.busy, bus.in_ready}), 64'd3);
        send_beat(8'h0A);
        wait_result("s6", 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
